robertsons_multiplier_control: RTL
==================================

# robertsons_multiplier_control

Sequential signed (two's-complement) multiplier core implementing Robertson's add-and-shift algorithm. It owns the accumulator, multiplier register and iteration counter, and sequences one add step and one arithmetic right-shift step per multiplier bit. It sits directly upstream of the 16-bit right-shift/load register, which captures the finished product. A start/busy/done handshake runs against the system controller.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits (16 at default).

- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  signed X; captured on accepted start.
- multiplier  input  WIDTH  signed Y; captured on accepted start.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  single-cycle pulse; product valid from this cycle.
- product  output  2*WIDTH  signed X*Y; held until the next completion.

## Operation
- Registers:
  - X: WIDTH bits.
  - A: accumulator, WIDTH+1 bits, sign-extended so add/subtract never overflows.
  - Q: WIDTH bits.
  - count: clog2(WIDTH) bits.
  - state.
  - product and done as output registers.
- Reset (async, reset_n=0): state=IDLE; A, Q, X, count, product = 0; busy=0; done=0.
- IDLE:
  - On start=1, load X=multiplicand, Q=multiplier, A=0, count=0, then go to ADD.
  - On start=0, hold.
- ADD:
  - If Q[0]=1 and count<WIDTH-1: A = A + sext(X).
  - If Q[0]=1 and count==WIDTH-1: A = A - sext(X). This is the sign-bit correction step.
  - If Q[0]=0: A unchanged.
  - Always go to SHIFT.
- SHIFT:
  - {A,Q} is shifted right arithmetically by 1: A[WIDTH] is replicated, A[0] enters Q[WIDTH-1], and Q[0] is discarded.
  - If count==WIDTH-1: product = {A_shifted[WIDTH-1:0], Q_shifted}, done=1, go to IDLE.
  - Otherwise: count=count+1, go to ADD.
- The ADD step's result feeds the SHIFT step through registers, not combinationally.
- Arithmetic width rules:
  - All add/subtract is done on WIDTH+1 bits.
  - The final A[WIDTH] is discarded, because the product always fits in 2*WIDTH signed bits, including (-2^(WIDTH-1))^2.
- busy = (state != IDLE), decoded from registered state.
- done is high for exactly one cycle, then self-clears.
- start while busy: ignored; operands are not re-captured.
- Operand inputs may change freely after the start edge.

## Timing
- The start edge is the rising edge where start=1 is sampled in IDLE; call it edge 0.
- busy rises after edge 0 and stays high through cycle 2*WIDTH.
- Edges 1..2*WIDTH alternate ADD and SHIFT, so there are WIDTH iterations.
- At edge 2*WIDTH (the final SHIFT):
  - product updates;
  - done rises;
  - busy falls.
- Latency: done and product are valid 2*WIDTH cycles after the start edge (16 at default).
- Back-to-back operation: start=1 during the done cycle is accepted, because the FSM is already in IDLE. The next done follows 2*WIDTH cycles later, giving a throughput of one result per 2*WIDTH+1 cycles maximum.
- Reset asserted mid-operation:
  - the operation aborts immediately (asynchronous);
  - outputs return to reset values;
  - no done pulse is issued;
  - after reset_n deasserts, the block idles until a new start.
- The downstream register's load enable is driven from done; product is stable for the whole done cycle and afterwards.

## Test plan
- Reset, then multiplicand=3, multiplier=5, start for 1 cycle -> busy for 16 cycles; done pulse at cycle 16; product=0x000F.
- Sign cases:
  - -3 × 5 -> product=0xFFF1.
  - 5 × -3 -> product=0xFFF1 (exercises the correction subtract).
  - -3 × -5 -> product=0x000F.
- Corner operands:
  - -128 × -128 -> 0x4000.
  - -128 × 127 -> 0xC080.
  - 127 × 127 -> 0x3F01.
  - 0 × -1 -> 0x0000.
  - Each exactly one done pulse.
- Start held high continuously with new operands after acceptance -> the first result uses the captured operands; the next start is accepted in the done cycle; done pulses 17 cycles apart; mid-operation operand changes have no effect.
- reset_n pulsed low at cycle 7 of an operation -> busy=0, done=0 and product=0 immediately; no done pulse follows; a fresh 2 × 3 then yields 0x0006.
- Random sweep of 1000 WIDTH=8 operand pairs against a signed reference model -> product and latency match on every run; done is never wider than 1 cycle.

Source files
------------

// File: rtl/robertsons_multiplier_control.sv
// Sequential two's-complement multiplier using Robertson's add-and-shift algorithm.
// One ADD and one SHIFT cycle per multiplier bit; the last add becomes a subtract that corrects for the multiplier's sign bit.
module robertsons_multiplier_control #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   multiplicand,
    input  logic signed [WIDTH-1:0]   multiplier,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] x_reg;
    logic signed [WIDTH:0]   acc;
    logic        [WIDTH-1:0] q_reg;
    logic        [CW-1:0]    count;

    logic signed [WIDTH:0]   x_ext;
    logic signed [WIDTH:0]   acc_sh;
    logic        [WIDTH-1:0] q_sh;
    logic                    last_iter;

    // The extra accumulator bit keeps the add/subtract from overflowing.
    function automatic logic signed [WIDTH:0] sext(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    assign x_ext     = sext(x_reg);
    assign acc_sh    = acc >>> 1;
    assign q_sh      = {acc[0], q_reg[WIDTH-1:1]};
    assign last_iter = (count == LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last_iter ? IDLE : ADD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_reg   <= '0;
            acc     <= '0;
            q_reg   <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg <= multiplicand;
                        q_reg <= multiplier;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                ADD: begin
                    if (q_reg[0]) begin
                        acc <= last_iter ? (acc - x_ext) : (acc + x_ext);
                    end
                end
                SHIFT: begin
                    acc   <= acc_sh;
                    q_reg <= q_sh;
                    // The final acc sign bit is redundant: the product always fits 2*WIDTH bits.
                    if (last_iter) begin
                        product <= {acc_sh[WIDTH-1:0], q_sh};
                        done    <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
